// File: rtl/cordic_vector_seq.sv
// Sequential CORDIC vectoring engine: converts a signed I/Q sample into
// an uncompensated magnitude and a binary-angle phase, one micro-rotation per clock.
module cordic_vector_seq #(
    parameter int ITERS = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               strobe_in,
    input  logic signed [15:0] xi,
    input  logic signed [15:0] yi,
    output logic               busy,
    output logic               strobe_out,
    output logic        [16:0] mag,
    output logic        [15:0] phase
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    state_t state, state_nxt;

    logic        [3:0]  count;
    logic signed [18:0] x, y;
    logic        [15:0] z;
    logic signed [18:0] xe, ye;
    logic signed [18:0] xs, ys;
    logic        [15:0] atan;
    logic               load, step, finish;

    // round(atan(2^-i) * 65536 / (2*pi))
    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'h2000;
            4'd1:    atan_lut = 16'h12E4;
            4'd2:    atan_lut = 16'h09FB;
            4'd3:    atan_lut = 16'h0511;
            4'd4:    atan_lut = 16'h028B;
            4'd5:    atan_lut = 16'h0146;
            4'd6:    atan_lut = 16'h00A3;
            4'd7:    atan_lut = 16'h0051;
            4'd8:    atan_lut = 16'h0029;
            4'd9:    atan_lut = 16'h0014;
            4'd10:   atan_lut = 16'h000A;
            4'd11:   atan_lut = 16'h0005;
            4'd12:   atan_lut = 16'h0003;
            4'd13:   atan_lut = 16'h0001;
            4'd14:   atan_lut = 16'h0001;
            default: atan_lut = 16'h0000;
        endcase
    endfunction

    assign xe   = {{3{xi[15]}}, xi};
    assign ye   = {{3{yi[15]}}, yi};
    assign xs   = x >>> count;
    assign ys   = y >>> count;
    assign atan = atan_lut(count);
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (strobe_in) begin
                        load      = 1'b1;
                        state_nxt = ITER;
                    end
                end
                ITER: begin
                    step = 1'b1;
                    if (count == LAST) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Left half-plane inputs are mirrored through the origin; 19 bits hold -(-32768).
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            strobe_out <= 1'b0;
            mag        <= '0;
            phase      <= '0;
        end else begin
            strobe_out <= finish;
            if (load) begin
                count <= '0;
                if (xi[15]) begin
                    x <= -xe;
                    y <= -ye;
                    z <= 16'h8000;
                end else begin
                    x <= xe;
                    y <= ye;
                    z <= 16'h0000;
                end
            end else if (step) begin
                count <= count + 4'd1;
                if (!y[18]) begin
                    x <= x + ys;
                    y <= y - xs;
                    z <= z + atan;
                end else begin
                    x <= x - ys;
                    y <= y + xs;
                    z <= z - atan;
                end
            end
            if (finish) begin
                mag   <= x[16:0];
                phase <= z;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vector_seq.sv
// Directed bench for cordic_vector_seq: table of I/Q vectors plus
// hand-written sequences for busy-strobe, back-to-back, reset and enable aborts.
module tb_cordic_vector_seq;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               strobe_in;
    logic signed [15:0] xi;
    logic signed [15:0] yi;
    logic               busy;
    logic               strobe_out;
    logic        [16:0] mag;
    logic        [15:0] phase;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        int                 em;
        int                 mt;
        logic        [15:0] ep;
        int                 pt;
    } vec_t;

    vec_t vecs[9];

    cordic_vector_seq #(.ITERS(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .strobe_in  (strobe_in),
        .xi         (xi),
        .yi         (yi),
        .busy       (busy),
        .strobe_out (strobe_out),
        .mag        (mag),
        .phase      (phase)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input longint got, input longint exp,
                         input longint tol);
        longint d;
        asserts++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, got, exp, tol);
        end
    endtask

    task automatic check_ph(input string nm, input logic [15:0] got,
                            input logic [15:0] exp, input int tol);
        logic signed [15:0] d;
        int ad;
        asserts++;
        d  = got - exp;
        ad = (d < 0) ? -int'(d) : int'(d);
        if (ad > tol) begin
            fails++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (tol %0d)", nm, got, exp, tol);
        end
    endtask

    // Called just after a clock edge; returns edges from load to strobe_out.
    task automatic convert(input string nm, input logic signed [15:0] xv,
                           input logic signed [15:0] yv, output int lat,
                           output logic [16:0] m, output logic [15:0] p);
        int idle_cnt;
        xi        = xv;
        yi        = yv;
        strobe_in = 1'b1;
        @(posedge clock);
        #1;
        strobe_in = 1'b0;
        lat       = -1;
        m         = '0;
        p         = '0;
        idle_cnt  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!busy) idle_cnt++;
            @(posedge clock);
            #1;
            if (strobe_out) begin
                lat = k;
                m   = mag;
                p   = phase;
                break;
            end
        end
        check({nm, "_lat"}, lat, 16, 0);
        check({nm, "_busy_run"}, idle_cnt, 0, 0);
        check({nm, "_busy_out"}, busy, 0, 0);
    endtask

    initial begin
        int               lat, n, c1, c2;
        logic      [16:0] m;
        logic      [15:0] p;

        vecs[0] = '{16'sd16384,  16'sd0,      26981, 4, 16'h0000, 2};
        vecs[1] = '{16'sd0,      16'sd16384,  26981, 4, 16'h4000, 2};
        vecs[2] = '{-16'sd16384, 16'sd0,      26981, 4, 16'h8000, 2};
        vecs[3] = '{-16'sd32768, -16'sd32768, 76315, 8, 16'hA000, 2};
        vecs[4] = '{16'sd16384,  16'sd16384,  38157, 8, 16'h2000, 4};
        vecs[5] = '{16'sd0,      -16'sd16384, 26981, 4, 16'hC000, 4};
        vecs[6] = '{-16'sd16384, 16'sd16384,  38157, 8, 16'h6000, 4};
        vecs[7] = '{16'sd0,      16'sd0,      0,     0, 16'h0000, -1};
        vecs[8] = '{16'sd20000,  -16'sd20000, 46579, 8, 16'hE000, 4};

        reset     = 1'b1;
        enable    = 1'b1;
        strobe_in = 1'b0;
        xi        = '0;
        yi        = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_busy", busy, 0, 0);
        check("rst_strobe", strobe_out, 0, 0);
        check("rst_mag", mag, 0, 0);
        check("rst_phase", phase, 0, 0);

        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            convert(nm, vecs[i].x, vecs[i].y, lat, m, p);
            check({nm, "_mag"}, m, vecs[i].em, vecs[i].mt);
            if (vecs[i].pt >= 0) check_ph({nm, "_phase"}, p, vecs[i].ep, vecs[i].pt);
        end

        // strobe_in while busy must be ignored
        @(posedge clock);
        #1;
        xi        = 16'sd16384;
        yi        = 16'sd16384;
        strobe_in = 1'b1;
        @(posedge clock);
        #1;
        n   = 0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            xi        = -16'sd32768;
            yi        = 16'sd5;
            strobe_in = (k == 3 || k == 10);
            @(posedge clock);
            #1;
            if (strobe_out) begin
                n++;
                lat = k;
                m   = mag;
                p   = phase;
            end
        end
        strobe_in = 1'b0;
        check("ign_count", n, 1, 0);
        check("ign_lat", lat, 16, 0);
        check("ign_mag", m, 38157, 8);
        check_ph("ign_phase", p, 16'h2000, 4);

        // back-to-back: second strobe_in lands in the strobe_out cycle
        convert("b2b_a", 16'sd16384, 16'sd0, lat, m, p);
        c1 = cyc;
        convert("b2b_b", 16'sd0, 16'sd16384, lat, m, p);
        c2 = cyc;
        check("b2b_gap", c2 - c1, 17, 0);
        check_ph("b2b_phase", p, 16'h4000, 2);

        // reset at load+7
        xi        = 16'sd16384;
        yi        = 16'sd0;
        strobe_in = 1'b1;
        @(posedge clock);
        #1;
        strobe_in = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rab_busy", busy, 0, 0);
        check("rab_strobe", strobe_out, 0, 0);
        check("rab_mag", mag, 0, 0);
        check("rab_phase", phase, 0, 0);
        n = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock);
            #1;
            if (strobe_out) n++;
        end
        check("rab_nostrobe", n, 0, 0);
        convert("rab_next", 16'sd0, -16'sd16384, lat, m, p);
        check("rab_next_mag", m, 26981, 4);
        check_ph("rab_next_phase", p, 16'hC000, 4);

        // enable drop mid-conversion
        convert("en_pre", 16'sd16384, 16'sd0, lat, m, p);
        xi        = 16'sd0;
        yi        = 16'sd16384;
        strobe_in = 1'b1;
        @(posedge clock);
        #1;
        strobe_in = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        enable = 1'b0;
        @(posedge clock);
        #1;
        enable = 1'b1;
        check("en_busy", busy, 0, 0);
        n = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock);
            #1;
            if (strobe_out) n++;
        end
        check("en_nostrobe", n, 0, 0);
        check("en_hold_mag", mag, 26981, 4);
        check_ph("en_hold_phase", phase, 16'h0000, 2);
        convert("en_next", -16'sd16384, 16'sd0, lat, m, p);
        check("en_next_mag", m, 26981, 4);
        check_ph("en_next_phase", p, 16'h8000, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
